siso_shift_ctrl: RTL and testbench
==================================

SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, word length in bits (legal range 2..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk SHALL be: input, 1 bit, single clock, all state updates on the rising edge.
REQ-004 Port clear SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port din SHALL be: input, WIDTH bits, parallel word to serialize.
REQ-006 Port din_valid SHALL be: input, 1 bit, din holds a word to transmit.
REQ-007 Port din_ready SHALL be: output, 1 bit, block can accept a word this cycle.
REQ-008 Port pause SHALL be: input, 1 bit, stalls shifting while high.
REQ-009 Port so SHALL be: output, 1 bit, serial data out, MSB first (left shift).
REQ-010 Port so_valid SHALL be: output, 1 bit, so carries a valid bit this cycle.
REQ-011 Port busy SHALL be: output, 1 bit, a word is in flight (state SHIFT or DONE).
REQ-012 Port done SHALL be: output, 1 bit, one-cycle pulse after the last bit.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE; state, the WIDTH-bit shift register and the bit counter SHALL all be registered.
REQ-014 IDLE: din_ready=1, so_valid=0, busy=0, done=0.
REQ-015 IDLE with din_valid=1 (the handshake): the block SHALL capture din into the shift register, load the counter with WIDTH-1, and go to SHIFT on the next edge.
REQ-016 IDLE with din_valid=0: the block SHALL stay in IDLE with the shift register unchanged.
REQ-017 SHIFT: din_ready=0, busy=1; so SHALL equal shreg[WIDTH-1]; so_valid SHALL equal !pause.
REQ-018 SHIFT with pause=0: the block SHALL shift shreg left by one (LSB filled with 0) and decrement the counter each edge.
REQ-019 SHIFT with pause=1: the block SHALL hold shreg, the counter and the state; so SHALL hold its value.
REQ-020 SHIFT with pause=0 and counter==0: the block SHALL go to DONE (last bit emitted this cycle); the counter SHALL NOT wrap.
REQ-021 DONE: done=1, busy=1, din_ready=0, so_valid=0; the block SHALL return to IDLE unconditionally on the next edge.
REQ-022 Latency: the first bit SHALL appear on so in the cycle after acceptance; with no pause, WIDTH consecutive so_valid cycles, then done, then din_ready=1 (WIDTH+2 cycles per word).
REQ-023 din_valid and din SHALL be ignored outside IDLE; no word is lost or queued.
REQ-024 When so_valid=0, so SHALL be 0 in IDLE and DONE.
REQ-025 pause SHALL have no effect in IDLE or DONE.

Reset
REQ-026 clear=1 at a rising edge SHALL force: state=IDLE, shreg=0, counter=0, so=0, so_valid=0, busy=0, done=0, din_ready=1 (after the edge).
REQ-027 clear SHALL take priority over every other input in every state, including mid-word SHIFT and DONE; the partial word SHALL be discarded and no done pulse SHALL be issued.
REQ-028 While clear=1, a din_valid=1 word SHALL NOT be accepted.

Verification
REQ-029 Basic: WIDTH=8, clear 1 cycle, din=8'hA5 with din_valid for 1 cycle -> so=1,0,1,0,0,1,0,1 with so_valid=1 on cycles +1..+8; done=1 on +9; din_ready=1 on +10.
REQ-030 Pause: din=8'hF0; pause=1 during output bits 3 and 4 (2 cycles) -> so_valid low for 2 cycles; so stream still 1,1,1,1,0,0,0,0; done on cycle +11.
REQ-031 Reset mid-operation: din=8'hFF; clear asserted after 4 bits -> next cycle IDLE, busy=0, so=0, din_ready=1; no done pulse.
REQ-032 Ignored input: din_valid held high with changing din during SHIFT -> only the originally accepted word appears on so; din_ready stays 0 until IDLE.
REQ-033 Back-to-back: din_valid held high with 8'h81 then 8'h7E -> second word accepted on the first IDLE cycle after done; streams 10000001 then 01111110; 10-cycle spacing between the first bits of the two words.
REQ-034 Boundary: WIDTH=2, din=2'b10 -> so=1,0 then done; counter never underflows; busy=1 for exactly 3 cycles.

Source files
------------

// File: rtl/siso_shift_ctrl.sv
// Parallel-in serial-out shifter: accepts one WIDTH-bit word in IDLE and emits it MSB first,
// with a pause stall and a one-cycle done pulse after the final bit.
module siso_shift_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             pause,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (din_valid) begin
          shreg_d = din;
          cnt_d   = CW'(WIDTH - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (!pause) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          // Counter stops at zero; the last bit leaves on this edge.
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    din_ready = 1'b0;
    so        = 1'b0;
    so_valid  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        din_ready = 1'b1;
      end
      StShift: begin
        busy     = 1'b1;
        so       = shreg_q[WIDTH-1];
        so_valid = !pause;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Scoreboard bench for siso_shift_ctrl: expected serial bits are queued when a word is driven
// and popped whenever so_valid is seen; per-cycle control outputs are checked against constants.
module tb_siso_shift_ctrl;

  logic       clk;
  logic       clear;
  logic [7:0] din;
  logic       din_valid, pause;
  logic       din_ready, so, so_valid, busy, done;
  logic [1:0] din2;
  logic       din_valid2, pause2;
  logic       din_ready2, so2, so_valid2, busy2, done2;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  siso_shift_ctrl #(.WIDTH(8)) u_dut (
    .clk      (clk),
    .clear    (clear),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .pause    (pause),
    .so       (so),
    .so_valid (so_valid),
    .busy     (busy),
    .done     (done)
  );

  siso_shift_ctrl #(.WIDTH(2)) u_dut2 (
    .clk      (clk),
    .clear    (clear),
    .din      (din2),
    .din_valid(din_valid2),
    .din_ready(din_ready2),
    .pause    (pause2),
    .so       (so2),
    .so_valid (so_valid2),
    .busy     (busy2),
    .done     (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are sampled at posedge+2.
  task automatic test_reset();
    logic [4:0] act;
    clear = 1'b1;
    din = 8'h5A;
    din_valid = 1'b1;
    din_valid2 = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    din_valid = 1'b0;
    din_valid2 = 1'b0;
    #1;
    act = {so, so_valid, busy, done, din_ready};
    checks++;
    if (act !== 5'b00001) begin
      errors++;
      $display("FAIL reset_w8: got %b, want 00001", act);
    end
    act = {so2, so_valid2, busy2, done2, din_ready2};
    checks++;
    if (act !== 5'b00001) begin
      errors++;
      $display("FAIL reset_w2: got %b, want 00001", act);
    end
    @(posedge clk); #1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: busy got %b, want 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    logic [3:0] act, exp;
    bit b;
    w = 8'hA5;
    din = w;
    din_valid = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready: got %b, want 1", din_ready);
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      act = {so_valid, busy, done, din_ready};
      exp = {c <= 8, c <= 9, c == 9, c == 10};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL basic_ctl_c%0d: got %b, want %b", c, act, exp);
      end
      if (so_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL basic_so_c%0d: got %b, want no bit", c, so);
        end else begin
          b = exp_q.pop_front();
          if (so !== b) begin
            errors++;
            $display("FAIL basic_so_c%0d: got %b, want %b", c, so, b);
          end
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pause();
    logic [7:0] w;
    logic [3:0] act, exp;
    bit b;
    w = 8'hF0;
    din = w;
    din_valid = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      pause = (c == 3 || c == 4 || c == 11);
      #1;
      act = {so_valid, busy, done, din_ready};
      exp = {c <= 10 && c != 3 && c != 4, c <= 11, c == 11, c == 12};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL pause_ctl_c%0d: got %b, want %b", c, act, exp);
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (so !== 1'b1) begin
          errors++;
          $display("FAIL pause_hold_c%0d: got %b, want 1", c, so);
        end
      end
      if (so_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pause_so_c%0d: got %b, want no bit", c, so);
        end else begin
          b = exp_q.pop_front();
          if (so !== b) begin
            errors++;
            $display("FAIL pause_so_c%0d: got %b, want %b", c, so, b);
          end
        end
      end
      @(posedge clk); #1;
    end
    pause = 1'b0;
  endtask

  task automatic test_clear_mid();
    logic [4:0] act;
    bit b;
    din = 8'hFF;
    din_valid = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (so_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL clear_so_valid_c%0d: got %b, want 1", c, so_valid);
      end else begin
        b = exp_q.pop_front();
        if (so !== b) begin
          errors++;
          $display("FAIL clear_so_c%0d: got %b, want %b", c, so, b);
        end
      end
      @(posedge clk); #1;
    end
    clear = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_before: got %b, want 1", busy);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    checks++;
    if (exp_q.size() != 4) begin
      errors++;
      $display("FAIL clear_remaining: got %0d, want 4", exp_q.size());
    end
    exp_q.delete();
    for (int c = 6; c <= 8; c++) begin
      #1;
      act = {so, so_valid, busy, done, din_ready};
      checks++;
      if (act !== 5'b00001) begin
        errors++;
        $display("FAIL clear_idle_c%0d: got %b, want 00001", c, act);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignored();
    logic [3:0] act, exp;
    bit b;
    din = 8'h3C;
    din_valid = 1'b1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(din[i]);
    @(posedge clk); #1;
    for (int c = 1; c <= 10; c++) begin
      din = 8'($urandom);
      din_valid = (c < 10);
      #1;
      act = {so_valid, busy, done, din_ready};
      exp = {c <= 8, c <= 9, c == 9, c == 10};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL ignored_ctl_c%0d: got %b, want %b", c, act, exp);
      end
      if (so_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ignored_so_c%0d: got %b, want no bit", c, so);
        end else begin
          b = exp_q.pop_front();
          if (so !== b) begin
            errors++;
            $display("FAIL ignored_so_c%0d: got %b, want %b", c, so, b);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_leftover: got %0d bits, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    logic [3:0] act, exp;
    int nvalid, first0, first1;
    bit b;
    w0 = 8'h81;
    w1 = 8'h7E;
    nvalid = 0;
    first0 = -1;
    first1 = -1;
    for (int i = 7; i >= 0; i--) exp_q.push_back(w0[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(w1[i]);
    din = w0;
    din_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      din = (c >= 2) ? w1 : w0;
      din_valid = (c <= 10);
      #1;
      act = {so_valid, busy, done, din_ready};
      exp = {(c <= 8) || (c >= 11 && c <= 18), (c <= 9) || (c >= 11 && c <= 19),
             c == 9 || c == 19, c == 10 || c == 20};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL b2b_ctl_c%0d: got %b, want %b", c, act, exp);
      end
      if (so_valid === 1'b1) begin
        if (nvalid == 0) first0 = c;
        if (nvalid == 8) first1 = c;
        nvalid++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_so_c%0d: got %b, want no bit", c, so);
        end else begin
          b = exp_q.pop_front();
          if (so !== b) begin
            errors++;
            $display("FAIL b2b_so_c%0d: got %b, want %b", c, so, b);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (first1 - first0 != 10 || first0 != 1) begin
      errors++;
      $display("FAIL b2b_spacing: got first bits at %0d and %0d, want 1 and 11", first0, first1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_leftover: got %0d bits, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_width2();
    logic [3:0] act, exp;
    int nbusy;
    bit b;
    nbusy = 0;
    din2 = 2'b10;
    din_valid2 = 1'b1;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    @(posedge clk); #1;
    din_valid2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      act = {so_valid2, busy2, done2, din_ready2};
      exp = {c <= 2, c <= 3, c == 3, c >= 4};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL w2_ctl_c%0d: got %b, want %b", c, act, exp);
      end
      if (busy2 === 1'b1) nbusy++;
      if (so_valid2 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL w2_so_c%0d: got %b, want no bit", c, so2);
        end else begin
          b = exp_q.pop_front();
          if (so2 !== b) begin
            errors++;
            $display("FAIL w2_so_c%0d: got %b, want %b", c, so2, b);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nbusy != 3) begin
      errors++;
      $display("FAIL w2_busy_cycles: got %0d, want 3", nbusy);
    end
    exp_q.delete();
  endtask

  initial begin
    clear = 1'b0;
    din = '0;
    din_valid = 1'b0;
    pause = 1'b0;
    din2 = '0;
    din_valid2 = 1'b0;
    pause2 = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_pause();
    test_clear_mid();
    test_ignored();
    test_back_to_back();
    test_width2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
